// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly after the program counter. It
// requests the word at current_pc from instruction memory over a req/ack
// handshake and places the returned word in the IF/ID pipeline register. It
// also gives the PC its next value (next_pc) and a hold signal (pc_hold).
//
// The stage copes with three kinds of disturbance:
//   - variable memory latency: the request stays up and the PC holds until ack.
//   - decode stalls: a word that arrives while decode is stalled is kept in a
//     one-entry buffer (HOLD state). No new request is made while it waits.
//   - control-flow redirects: IF/ID is flushed. If a fetch is still pending,
//     its reply is waited out and thrown away (DROP state), because a request
//     can never be withdrawn.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   current_pc      PC register output
//   next_pc         value for the PC to load
//   pc_hold         1 = PC keeps its value this cycle
//   redirect        taken branch/jump from a later stage (single-cycle)
//   redirect_target target address when redirect = 1
//   id_stall        decode cannot accept a new instruction
//   imem_req        fetch request
//   imem_addr       fetch address, stable while imem_req = 1
//   imem_ack        one-cycle pulse, imem_rdata valid
//   imem_rdata      fetched instruction
//   if_id_valid     IF/ID register holds a live instruction
//   if_id_instr     registered instruction
//   if_id_pc4       registered fetch address + PC_INC
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_INC     = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] current_pc,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  pc_hold,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  id_stall,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request current_pc
    DROP  = 2'd1,  // wait out a stale request that was issued before a redirect
    HOLD  = 2'd2   // fetched word is buffered while decode is stalled
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_addr_q;      // address of the request in flight
  logic [DATA_WIDTH-1:0] r_buf_instr;   // buffered word; only meaningful in HOLD
  logic [DATA_WIDTH-1:0] r_buf_pc4;
  logic [DATA_WIDTH-1:0] w_pc_plus;
  logic                  w_flush;
  logic                  w_load_mem;
  logic                  w_load_buf;
  logic                  w_buf_wr;

  // The addition wraps modulo 2^DATA_WIDTH.
  assign w_pc_plus = current_pc + DATA_WIDTH'(PC_INC);
  assign next_pc   = redirect ? redirect_target : w_pc_plus;

  // imem_req is gated directly by rst so that it drops the moment reset is
  // asserted, without waiting for the state register to settle.
  assign imem_req  = rst && (r_state != HOLD);
  assign imem_addr = (r_state == DROP) ? r_addr_q : current_pc;

  // The PC advances only when the current word has been consumed, or when it
  // must take a redirect target.
  assign pc_hold = !( redirect
                   || ((r_state == FETCH) && imem_ack && !id_stall)
                   || ((r_state == HOLD)  && !id_stall));

  // Next-state logic and IF/ID control.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned. An unassigned path would infer a latch.
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_load_mem  = 1'b0;
    w_load_buf  = 1'b0;
    w_buf_wr    = 1'b0;
    unique case (r_state)
      FETCH: begin
        if (redirect) begin
          // An acked word is already out of date. An un-acked request still
          // has to complete, so it is waited out in DROP.
          w_flush     = 1'b1;
          w_state_nxt = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          if (!id_stall) begin
            w_load_mem = 1'b1;
          end else begin
            w_buf_wr    = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      DROP: begin
        // A further redirect only re-flushes and moves the PC. The stale
        // request still ends on its own ack.
        w_flush = redirect;
        if (imem_ack) begin
          w_state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_state_nxt = FETCH;
        end else if (!id_stall) begin
          w_load_buf  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // State and request-address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_addr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples its pre-edge value no matter what order the statements run in.
      r_state <= w_state_nxt;
      if (r_state == FETCH) begin
        r_addr_q <= current_pc;
      end
    end
  end

  // Skid buffer for a word that arrives while decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the buffer is reset even though its contents are only used in
      // HOLD. This keeps the values that simulation shows deterministic from
      // the first cycle.
      r_buf_instr <= '0;
      r_buf_pc4   <= '0;
    end else if (w_buf_wr) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc4   <= w_pc_plus;
    end
  end

  // IF/ID pipeline register. A flush wins over every load, and fields hold
  // otherwise, which covers the decode-stall case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
    end else if (w_flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
    end else if (w_load_mem) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem_rdata;
      if_id_pc4   <= w_pc_plus;
    end else if (w_load_buf) begin
      if_id_valid <= 1'b1;
      if_id_instr <= r_buf_instr;
      if_id_pc4   <= r_buf_pc4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. The bench plays the role of the PC
// register: it loads next_pc when pc_hold is low and resets to 0. It also
// plays instruction memory, driving ack/rdata by hand in each scenario.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// 2 time units after it.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pc;
  logic [DW-1:0] next_pc;
  logic          pc_hold;
  logic          redirect;
  logic [DW-1:0] redirect_target;
  logic          id_stall;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          if_id_valid;
  logic [DW-1:0] if_id_instr;
  logic [DW-1:0] if_id_pc4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(DW), .PC_INC(4), .NOP_WORD(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .current_pc      (pc),
    .next_pc         (next_pc),
    .pc_hold         (pc_hold),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4)
  );

  // Advance one clock. The bench PC register is updated from the values
  // sampled just before the edge. Afterwards the time is edge + 2.
  task automatic cycle();
    logic          hold_s;
    logic [DW-1:0] next_s;
    hold_s = pc_hold;
    next_s = next_pc;
    @(posedge clk);
    #1;
    if (!rst)         pc = '0;
    else if (!hold_s) pc = next_s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = '0; redirect = 1'b0; redirect_target = '0;
    id_stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", if_id_valid); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", if_id_instr, NOP); end
    n_checks++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", if_id_pc4); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %h want 0", imem_req); end
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req got %h want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [DW-1:0] words [3];
    words[0] = 32'h2008_0001; words[1] = 32'h2009_0002; words[2] = 32'h200A_0003;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = words[i];
      #1;
      n_checks++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL zw_hold[%0d] got %h want 0", i, pc_hold); end
      n_checks++; if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_addr[%0d] got %h want %h", i, imem_addr, 32'(i * 4)); end
      cycle();
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d] got %h want 1", i, if_id_valid); end
      n_checks++; if (if_id_instr !== words[i]) begin n_fail++; $display("FAIL zw_instr[%0d] got %h want %h", i, if_id_instr, words[i]); end
      n_checks++; if (if_id_pc4 !== 32'((i + 1) * 4)) begin n_fail++; $display("FAIL zw_pc4[%0d] got %h want %h", i, if_id_pc4, 32'((i + 1) * 4)); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_latency();
    pc = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lat_req[%0d] got %h want 1", i, imem_req); end
      n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL lat_addr[%0d] got %h want 10", i, imem_addr); end
      n_checks++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL lat_hold[%0d] got %h want 1", i, pc_hold); end
      cycle();
    end
    imem_ack = 1'b1; imem_rdata = 32'h3C00_1234;
    #1;
    n_checks++; if (next_pc !== 32'h14) begin n_fail++; $display("FAIL lat_next got %h want 14", next_pc); end
    n_checks++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL lat_ack_hold got %h want 0", pc_hold); end
    cycle();
    imem_ack = 1'b0;
    n_checks++; if (if_id_instr !== 32'h3C00_1234) begin n_fail++; $display("FAIL lat_instr got %h want 3c001234", if_id_instr); end
    n_checks++; if (if_id_pc4 !== 32'h14) begin n_fail++; $display("FAIL lat_pc4 got %h want 14", if_id_pc4); end
  endtask

  task automatic test_stall();
    pc = 32'h40;
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222; id_stall = 1'b1;
    #1;
    n_checks++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL st_ack_hold got %h want 1", pc_hold); end
    cycle();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req got %h want 0", imem_req); end
    n_checks++; if (if_id_instr !== 32'h3C00_1234) begin n_fail++; $display("FAIL st_instr_kept got %h want 3c001234", if_id_instr); end
    n_checks++; if (if_id_pc4 !== 32'h14) begin n_fail++; $display("FAIL st_pc4_kept got %h want 14", if_id_pc4); end
    n_checks++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL st_hold got %h want 1", pc_hold); end
    cycle();
    id_stall = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req2 got %h want 0", imem_req); end
    n_checks++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL st_release_hold got %h want 0", pc_hold); end
    n_checks++; if (next_pc !== 32'h44) begin n_fail++; $display("FAIL st_next got %h want 44", next_pc); end
    cycle();
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid got %h want 1", if_id_valid); end
    n_checks++; if (if_id_instr !== 32'h1111_2222) begin n_fail++; $display("FAIL st_instr got %h want 11112222", if_id_instr); end
    n_checks++; if (if_id_pc4 !== 32'h44) begin n_fail++; $display("FAIL st_pc4 got %h want 44", if_id_pc4); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL st_next_req got req=%h addr=%h want req=1 addr=44", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drop();
    pc = 32'h20;
    #1;
    n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr got %h want 20", imem_addr); end
    cycle();
    redirect = 1'b1; redirect_target = 32'h100;
    #1;
    n_checks++; if (next_pc !== 32'h100 || pc_hold !== 1'b0) begin n_fail++; $display("FAIL rd_next got next=%h hold=%h want next=100 hold=0", next_pc, pc_hold); end
    cycle();
    redirect = 1'b0;
    #1;
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush_valid got %h want 0", if_id_valid); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL rd_flush_instr got %h want %h", if_id_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_stale_req got req=%h addr=%h want req=1 addr=20", imem_req, imem_addr); end
    n_checks++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL rd_drop_hold got %h want 1", pc_hold); end
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL rd_stale_ack_hold got %h want 1", pc_hold); end
    cycle();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_fail++; $display("FAIL rd_discard got valid=%h instr=%h want valid=0 instr=%h", if_id_valid, if_id_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_new_req got req=%h addr=%h want req=1 addr=100", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    cycle();
    n_checks++; if (if_id_instr !== 32'hAAAA_0001 || if_id_pc4 !== 32'h104) begin n_fail++; $display("FAIL rh_load got instr=%h pc4=%h want aaaa0001/104", if_id_instr, if_id_pc4); end
    imem_rdata = 32'hBBBB_0002; id_stall = 1'b1;
    cycle();
    imem_ack = 1'b0;
    n_checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hAAAA_0001) begin n_fail++; $display("FAIL rh_hold_kept got valid=%h instr=%h want 1/aaaa0001", if_id_valid, if_id_instr); end
    redirect = 1'b1; redirect_target = 32'h200;
    #1;
    n_checks++; if (pc_hold !== 1'b0 || next_pc !== 32'h200) begin n_fail++; $display("FAIL rh_next got hold=%h next=%h want 0/200", pc_hold, next_pc); end
    cycle();
    redirect = 1'b0; id_stall = 1'b0;
    #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_fail++; $display("FAIL rh_flush got valid=%h instr=%h want 0/%h", if_id_valid, if_id_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rh_req got req=%h addr=%h want 1/200", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hCCCC_0003;
    cycle();
    imem_ack = 1'b0;
    n_checks++; if (if_id_instr !== 32'hCCCC_0003 || if_id_pc4 !== 32'h204) begin n_fail++; $display("FAIL rh_after got instr=%h pc4=%h want cccc0003/204", if_id_instr, if_id_pc4); end
  endtask

  task automatic test_wrap_reset();
    pc = 32'hFFFF_FFFC;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h want 0", next_pc); end
    cycle();
    imem_ack = 1'b0;
    n_checks++; if (if_id_pc4 !== 32'h0 || if_id_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL wrap_load got pc4=%h instr=%h want 0/12345678", if_id_pc4, if_id_instr); end
    pc = 32'h80;
    cycle();
    // Reset lands between clock edges while the request to 0x80 is pending.
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %h want 0", if_id_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL async_req got %h want 0", imem_req); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL async_instr got %h want %h", if_id_instr, NOP); end
    pc = '0;
    cycle();
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_release got req=%h addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_drop();
    test_redirect_hold();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
